// File: rtl/pq_ctrl.sv
// Valid/ready front-end for the sorted priority queue: arbitrates insert/pop
// requests, issues one single-cycle queue command per grant, tracks occupancy.
module pq_ctrl #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             r,
  input  logic             flush,
  input  logic             ins_valid,
  input  logic [WIDTH-1:0] ins_data,
  output logic             ins_ready,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] q_newVal,
  output logic             q_loadIn,
  output logic             q_shiftOut,
  output logic             q_clear,
  input  logic [WIDTH-1:0] q_top
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CLR} state_t;

  state_t           state, state_nxt;
  logic             last_pop;
  logic [WIDTH-1:0] data_q;
  logic             pop_elig, ins_elig;
  logic             grant_pop, grant_ins;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign q_newVal  = data_q;
  assign ins_ready = grant_ins;
  assign pop_ready = grant_pop;

  always_comb begin
    state_nxt  = IDLE;
    grant_pop  = 1'b0;
    grant_ins  = 1'b0;
    q_loadIn   = 1'b0;
    q_shiftOut = 1'b0;
    q_clear    = 1'b0;
    pop_elig   = pop_valid & ~empty;
    ins_elig   = ins_valid & ~full;
    unique case (state)
      IDLE: begin
        // Round-robin on contention: last_pop flips the winner each grant
        if (flush) begin
          state_nxt = CLR;
        end else if (pop_elig && (!ins_elig || !last_pop)) begin
          grant_pop = 1'b1;
          state_nxt = SHIFT;
        end else if (ins_elig) begin
          grant_ins = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:  q_loadIn   = 1'b1;
      SHIFT: q_shiftOut = 1'b1;
      CLR:   q_clear    = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      state     <= CLR;
      count     <= '0;
      last_pop  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state == SHIFT);
      if (grant_ins) begin
        data_q   <= ins_data;
        last_pop <= 1'b0;
      end
      if (grant_pop) last_pop <= 1'b1;
      unique case (state)
        LOAD:  count <= count + 1'b1;
        SHIFT: begin
          count    <= count - 1'b1;
          rsp_data <= q_top;
        end
        CLR:   count <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_ctrl.sv
// Bench for pq_ctrl: behavioural sorted-queue model on the q_* port, response
// scoreboard keyed on pop acceptance, cycle table plus corner-case sequences.
module tb_pq_ctrl;

  localparam int W     = 1;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          ck = 1'b0;
  logic          r = 1'b1;
  logic          flush = 1'b0;
  logic          ins_valid = 1'b0;
  logic [W-1:0]  ins_data = '0;
  logic          ins_ready;
  logic          pop_valid = 1'b0;
  logic          pop_ready;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [W-1:0]  q_newVal;
  logic          q_loadIn, q_shiftOut, q_clear;
  logic [W-1:0]  q_top;

  pq_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .ck(ck), .r(r), .flush(flush),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .count(count), .full(full), .empty(empty),
    .q_newVal(q_newVal), .q_loadIn(q_loadIn), .q_shiftOut(q_shiftOut),
    .q_clear(q_clear), .q_top(q_top)
  );

  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int cmd();
    return int'({q_clear, q_shiftOut, q_loadIn});
  endfunction

  always @(posedge ck) cyc <= cyc + 1;

  // Sorted queue model, largest value at the top
  logic [W-1:0] mem [DEPTH];
  int msz = 0;
  logic [W-1:0] t [DEPTH];
  int n, p;
  assign q_top = (msz > 0) ? mem[0] : '0;

  always @(posedge ck) begin
    t = mem;
    n = msz;
    if (q_clear) begin
      n = 0;
    end else if (q_loadIn && n < DEPTH) begin
      p = n;
      while (p > 0 && t[p-1] < q_newVal) begin
        t[p] = t[p-1];
        p--;
      end
      t[p] = q_newVal;
      n++;
    end else if (q_shiftOut && n > 0) begin
      for (int i = 0; i < DEPTH - 1; i++) t[i] = t[i+1];
      n--;
    end
    mem <= t;
    msz <= n;
  end

  // Scoreboard: expected data and due cycle pushed at pop acceptance
  logic [W-1:0] exp_d [$];
  int           exp_c [$];

  always @(posedge r) begin
    exp_d.delete();
    exp_c.delete();
  end

  always @(negedge ck) begin
    if (!r) begin
      if (pop_valid && pop_ready) begin
        exp_d.push_back(q_top);
        exp_c.push_back(cyc + 2);
      end
      if (rsp_valid) begin
        if (exp_d.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_data", int'(rsp_data), int'(exp_d.pop_front()));
          chk("rsp_latency", cyc, exp_c.pop_front());
        end
      end
      if (!$onehot0({q_clear, q_shiftOut, q_loadIn})) chk("cmd_onehot", cmd(), 0);
    end
  end

  typedef struct {
    logic fl, iv, d, pv;
    logic er_i, er_p;
    int   cnt;
    int   cm;
  } vec_t;

  vec_t tbl [13];

  task automatic do_ins(input logic [W-1:0] d);
    int k = 0;
    ins_valid = 1'b1;
    ins_data  = d;
    @(negedge ck);
    while (!ins_ready && k < 50) begin
      k++;
      @(negedge ck);
    end
    if (k >= 50) chk("ins_timeout", 0, 1);
    @(posedge ck); #1;
    ins_valid = 1'b0;
    @(posedge ck); #1;
  endtask

  task automatic do_pop();
    int k = 0;
    pop_valid = 1'b1;
    @(negedge ck);
    while (!pop_ready && k < 50) begin
      k++;
      @(negedge ck);
    end
    if (k >= 50) chk("pop_timeout", 0, 1);
    @(posedge ck); #1;
    pop_valid = 1'b0;
    @(posedge ck); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pc, g;
    int grants [4];

    //            fl iv d  pv ri rp cnt cmd
    tbl[0]  = '{0, 1, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{0, 1, 1, 0, 1, 0, 2, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 2, 1};
    tbl[6]  = '{0, 0, 0, 1, 0, 1, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 3, 2};
    tbl[8]  = '{0, 0, 0, 1, 0, 1, 2, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 2, 2};
    tbl[10] = '{0, 0, 0, 1, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 2};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0};

    // Reset release: first cycle is CLR, readies held low even with requests
    repeat (2) @(posedge ck);
    #1 r = 1'b0;
    pop_valid = 1'b1;
    @(negedge ck);
    chk("rst_cmd", cmd(), 4);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_pop_ready", int'(pop_ready), 0);
    chk("rst_ins_ready", int'(ins_ready), 0);
    @(posedge ck); #1;
    pop_valid = 1'b0;

    // Inserts 1,0,1 then three pops, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      flush = tbl[i].fl;
      ins_valid = tbl[i].iv;
      ins_data = tbl[i].d;
      pop_valid = tbl[i].pv;
      @(negedge ck);
      chk($sformatf("tbl%0d_ins_ready", i), int'(ins_ready), int'(tbl[i].er_i));
      chk($sformatf("tbl%0d_pop_ready", i), int'(pop_ready), int'(tbl[i].er_p));
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_cmd", i), cmd(), tbl[i].cm);
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].cnt == 0));
      @(posedge ck); #1;
    end
    ins_valid = 1'b0;
    pop_valid = 1'b0;

    // Fill to capacity, then a held seventh insert waits for a pop
    for (int i = 0; i < DEPTH; i++) do_ins(W'($urandom_range(0, 1)));
    @(negedge ck);
    chk("fill_count", int'(count), 6);
    chk("fill_full", int'(full), 1);
    @(posedge ck); #1;
    ins_valid = 1'b1;
    ins_data  = 1'b1;
    repeat (3) begin
      @(negedge ck);
      chk("full_ins_ready", int'(ins_ready), 0);
    end
    @(posedge ck); #1;
    pop_valid = 1'b1;
    @(negedge ck);
    chk("full_pop_ready", int'(pop_ready), 1);
    chk("full_ins_blocked", int'(ins_ready), 0);
    pc = cyc;
    @(posedge ck); #1;
    pop_valid = 1'b0;
    k = 0;
    @(negedge ck);
    while (!ins_ready && k < 50) begin
      k++;
      @(negedge ck);
    end
    chk("ins7_latency", cyc - pc, 2);
    @(posedge ck); #1;
    ins_valid = 1'b0;
    @(posedge ck); #1;
    @(negedge ck);
    chk("ins7_count", int'(count), 6);
    @(posedge ck); #1;

    repeat (DEPTH) do_pop();
    @(negedge ck);
    chk("drain_count", int'(count), 0);
    chk("drain_empty", int'(empty), 1);
    @(posedge ck); #1;

    // Pop requested while empty is never granted
    pop_valid = 1'b1;
    repeat (10) begin
      @(negedge ck);
      chk("empty_pop_ready", int'(pop_ready), 0);
      chk("empty_shift", int'(q_shiftOut), 0);
      chk("empty_rsp_valid", int'(rsp_valid), 0);
    end
    @(posedge ck); #1;
    pop_valid = 1'b0;

    // Contention at count 3 alternates pop/insert
    do_ins(1'b1);
    do_ins(1'b0);
    do_ins(1'b1);
    ins_valid = 1'b1;
    ins_data  = 1'b0;
    pop_valid = 1'b1;
    g = 0;
    k = 0;
    while (g < 4 && k < 40) begin
      @(negedge ck);
      k++;
      chk("alt_count_range", int'(count >= 2 && count <= 3), 1);
      if (pop_ready) begin
        grants[g] = 2;
        g++;
      end else if (ins_ready) begin
        grants[g] = 1;
        g++;
      end
      if (g < 4) begin
        @(posedge ck); #1;
      end
    end
    @(posedge ck); #1;
    ins_valid = 1'b0;
    pop_valid = 1'b0;
    chk("alt_grants", g, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_grant%0d", i), grants[i], (i % 2 == 0) ? 2 : 1);
    @(posedge ck); #1;
    @(negedge ck);
    chk("alt_end_count", int'(count), 3);
    @(posedge ck); #1;

    // Flush at count 4
    do_ins(1'b1);
    flush = 1'b1;
    ins_valid = 1'b1;
    @(negedge ck);
    chk("flush_count_before", int'(count), 4);
    chk("flush_ins_ready", int'(ins_ready), 0);
    @(posedge ck); #1;
    flush = 1'b0;
    ins_valid = 1'b0;
    @(negedge ck);
    chk("flush_cmd", cmd(), 4);
    @(posedge ck); #1;
    @(negedge ck);
    chk("flush_count_after", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    @(posedge ck); #1;

    // Asynchronous reset pulse during SHIFT drops the response
    do_ins(1'b1);
    do_ins(1'b0);
    pop_valid = 1'b1;
    k = 0;
    @(negedge ck);
    while (!pop_ready && k < 50) begin
      k++;
      @(negedge ck);
    end
    @(posedge ck); #1;
    pop_valid = 1'b0;
    chk("rstmid_shift", int'(q_shiftOut), 1);
    #1 r = 1'b1;
    #2 r = 1'b0;
    @(negedge ck);
    chk("rstmid_cmd", cmd(), 4);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_rsp_valid", int'(rsp_valid), 0);
    repeat (3) begin
      @(negedge ck);
      chk("rstmid_no_rsp", int'(rsp_valid), 0);
    end

    chk("sb_drained", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
